// File: rtl/multicycle_alu_pkg.sv
// Shared definitions for the multi-cycle ALU and the ALU control decode:
// the alu_op code points, FSM state encoding and the default datapath width.
package multicycle_alu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_BEQ  = 4'd10,
    ALU_BNE  = 4'd11,
    ALU_BLT  = 4'd12,
    ALU_BGE  = 4'd13,
    ALU_BLTU = 4'd14,
    ALU_BGEU = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/multicycle_alu_alu_comb.sv
// Single-cycle part of the ALU: add/sub, logic ops, set-less-than and the
// branch condition. Shift codes produce zero here; shifting lives in the top.
//   op_i     : alu_op code
//   a_i, b_i : operands
//   result_o : computed result (0 for branches and shifts)
//   bcond_o  : branch taken (0 for non-branch ops)
module multicycle_alu_alu_comb
  import multicycle_alu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [3:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] result_o,
  output logic         bcond_o
);

  logic eq, lt_s, lt_u;

  always_comb begin
    eq       = (a_i == b_i);
    lt_s     = ($signed(a_i) < $signed(b_i));
    lt_u     = (a_i < b_i);
    result_o = '0;
    bcond_o  = 1'b0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLT:  result_o = {{(W-1){1'b0}}, lt_s};
      ALU_SLTU: result_o = {{(W-1){1'b0}}, lt_u};
      ALU_BEQ:  bcond_o  = eq;
      ALU_BNE:  bcond_o  = !eq;
      ALU_BLT:  bcond_o  = lt_s;
      ALU_BGE:  bcond_o  = !lt_s;
      ALU_BLTU: bcond_o  = lt_u;
      ALU_BGEU: bcond_o  = !lt_u;
      default:  ;
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU with valid/ready handshake on both sides. Non-shift ops
// finish one edge after acceptance; shifts iterate one bit per edge.
// Build option: MULTICYCLE_ALU_BARREL_SHIFT_EN selects a combinational
// barrel shifter so shifts also finish at latency 1 (no SHIFT state/counter).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (alu_op, alu_in_1, alu_in_2)
//   kill                : synchronous flush, returns to IDLE
//   out_valid/out_ready : result handshake (alu_result, alu_bcond)
module multicycle_alu
  import multicycle_alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_in_1,
  input  logic [XLEN-1:0] alu_in_2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            alu_bcond
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              bcond_q, bcond_d;
  logic [XLEN-1:0]   comb_res;
  logic              comb_bcond;
  logic [SHAMT_W-1:0] shamt;
  logic              accept;

`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
  logic [XLEN-1:0]   barrel;
`else
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
`endif

  assign shamt  = alu_in_2[SHAMT_W-1:0];
  assign accept = in_valid && (state_q == ST_IDLE) && !kill;

  multicycle_alu_alu_comb #(.W(XLEN)) u_alu_comb (
    .op_i     (alu_op),
    .a_i      (alu_in_1),
    .b_i      (alu_in_2),
    .result_o (comb_res),
    .bcond_o  (comb_bcond)
  );

`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
  always_comb begin
    case (alu_op)
      ALU_SLL: barrel = alu_in_1 << shamt;
      ALU_SRL: barrel = alu_in_1 >> shamt;
      default: barrel = $unsigned($signed(alu_in_1) >>> shamt);
    endcase
  end
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; kill overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_DONE;
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
          if (is_shift(alu_op) && (shamt != '0)) state_d = ST_SHIFT;
`endif
        end
      end
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
      ST_SHIFT: if (cnt_q == SHAMT_W'(1)) state_d = ST_DONE;
`endif
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (kill) state_d = ST_IDLE;
  end

  // Output logic
  always_comb begin
    in_ready   = (state_q == ST_IDLE);
    out_valid  = (state_q == ST_DONE);
    alu_result = res_q;
    alu_bcond  = bcond_q;
  end

  // Datapath next values
  always_comb begin
    res_d   = res_q;
    bcond_d = bcond_q;
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
    cnt_d   = cnt_q;
    op_d    = op_q;
`endif
    if (kill) begin
      res_d   = '0;
      bcond_d = 1'b0;
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
      cnt_d   = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_shift(alu_op)) begin
              bcond_d = 1'b0;
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
              res_d   = barrel;
`else
              // Working register starts as operand A; shamt=0 leaves it as is
              res_d   = alu_in_1;
              cnt_d   = shamt;
              op_d    = alu_op;
`endif
            end else begin
              res_d   = comb_res;
              bcond_d = comb_bcond;
            end
          end
        end
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
        ST_SHIFT: begin
          case (op_q)
            ALU_SLL: res_d = res_q << 1;
            ALU_SRL: res_d = res_q >> 1;
            default: res_d = {res_q[XLEN-1], res_q[XLEN-1:1]};
          endcase
          cnt_d = cnt_q - SHAMT_W'(1);
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q   <= '0;
      bcond_q <= 1'b0;
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
      cnt_q   <= '0;
      op_q    <= '0;
`endif
    end else begin
      res_q   <= res_d;
      bcond_q <= bcond_d;
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
      cnt_q   <= cnt_d;
      op_q    <= op_d;
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: scoreboard of expected results pushed at
// accept time and popped when out_valid appears, plus kill and reset cases.
module tb_multicycle_alu;
  import multicycle_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_in_1;
  logic [31:0] alu_in_2;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        alu_bcond;

  typedef struct {
    logic [31:0] res;
    logic        bc;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  int unsigned n_total = 0;

`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
  localparam logic BARREL = 1'b1;
`else
  localparam logic BARREL = 1'b0;
`endif

  multicycle_alu #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .alu_in_1   (alu_in_1),
    .alu_in_2   (alu_in_2),
    .kill       (kill),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .alu_bcond  (alu_bcond)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned exp_lat(input logic [3:0] op, input logic [31:0] b);
    if (!BARREL && is_shift(op)) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic bc);
    r  = '0;
    bc = 1'b0;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_BEQ:  bc = (a == b);
      ALU_BNE:  bc = (a != b);
      ALU_BLT:  bc = ($signed(a) < $signed(b));
      ALU_BGE:  bc = ($signed(a) >= $signed(b));
      ALU_BLTU: bc = (a < b);
      default:  bc = (a >= b);
    endcase
  endfunction

  // Issue one op, measure latency, hold off the consumer for 'stall' cycles,
  // then consume and confirm the IDLE bubble.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic eb,
                        input int unsigned stall);
    exp_t e;
    exp_t got;
    int unsigned lat;
    check({tag, "_pre_in_ready"}, {31'b0, in_ready}, 32'd1);
    e.res = er;
    e.bc  = eb;
    e.lat = exp_lat(op, b);
    sb.push_back(e);
    in_valid  = 1'b1;
    alu_op    = op;
    alu_in_1  = a;
    alu_in_2  = b;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, e.lat);
    check({tag, "_busy_in_ready"}, {31'b0, in_ready}, 32'd0);
    for (int unsigned i = 0; i < stall; i++) begin
      check({tag, "_held_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_held_result"}, alu_result, er);
      check({tag, "_held_in_ready"}, {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    got = sb.pop_front();
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_result"}, alu_result, got.res);
    check({tag, "_bcond"}, {31'b0, alu_bcond}, {31'b0, got.bc});
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_consumed"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_bubble_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic        bc;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        seen_valid;

    reset = 1'b1; in_valid = 1'b0; alu_op = '0; alu_in_1 = '0; alu_in_2 = '0;
    kill = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", alu_result, 32'd0);
    check("rst_bcond", {31'b0, alu_bcond}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    run_op("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 0);
    run_op("sra4", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 0);
    run_op("sll31", ALU_SLL, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 0);
    run_op("srl0", ALU_SRL, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 0);
    run_op("srl_hi_amt", ALU_SRL, 32'hF000_0000, 32'hFFFF_FFE4, 32'h0F00_0000, 1'b0, 0);
    run_op("bltu", ALU_BLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
    run_op("blt", ALU_BLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
    run_op("beq", ALU_BEQ, 32'd5, 32'd5, 32'd0, 1'b1, 0);
    run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0);
    run_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0);
    run_op("sub_stall", ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 3);

    for (int unsigned i = 0; i < 10; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = is_shift(op) ? 32'($urandom_range(0, 9)) : $urandom;
      if (i == 0) b = a;
      model(op, a, b, r, bc);
      run_op("rand", op, a, b, r, bc, i % 2);
    end

    // kill during SLL by 20, on the 7th edge after acceptance
    in_valid = 1'b1; alu_op = ALU_SLL; alu_in_1 = 32'd1; alu_in_2 = 32'd20; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen_valid = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (out_valid !== BARREL) seen_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("kill_pre_valid", {31'b0, seen_valid}, 32'd0);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_idle_in_ready", {31'b0, in_ready}, 32'd1);
    check("kill_out_valid", {31'b0, out_valid}, 32'd0);
    seen_valid = 1'b0;
    for (int unsigned i = 0; i < 25; i++) begin
      if (out_valid !== 1'b0) seen_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("kill_never_valid", {31'b0, seen_valid}, 32'd0);

    // kill together with in_valid in IDLE: nothing accepted
    in_valid = 1'b1; kill = 1'b1; alu_op = ALU_ADD; alu_in_1 = 32'd9; alu_in_2 = 32'd9;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    check("kill_idle_no_accept", {31'b0, out_valid}, 32'd0);
    check("kill_idle_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("kill_idle_still_idle", {31'b0, out_valid}, 32'd0);

    // asynchronous reset mid-shift
    in_valid = 1'b1; alu_op = ALU_SRA; alu_in_1 = 32'h8000_0000; alu_in_2 = 32'd30;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_result_nonzero", {31'b0, (alu_result != 32'd0)}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_result", alu_result, 32'd0);
    check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_bcond", {31'b0, alu_bcond}, 32'd0);
    #3;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    run_op("post_rst_sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
